// File: rtl/otp_key_sequencer.sv
// otp_key_sequencer: one-time-pad key loader and plaintext XOR sequencer that never reuses a key word
module otp_key_sequencer #(
    parameter int DATA_W    = 8,
    parameter int KEY_WORDS = 4,
    localparam int CW       = $clog2(KEY_WORDS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              key_valid,
    input  logic [DATA_W-1:0] key_data,
    output logic              key_ready,
    input  logic              pt_valid,
    input  logic [DATA_W-1:0] pt_data,
    output logic              pt_ready,
    output logic              ct_valid,
    output logic [DATA_W-1:0] ct_data,
    input  logic              ct_ready,
    output logic              busy,
    output logic              exhausted,
    output logic [CW-1:0]     words_left
);
    localparam int IW = $clog2(KEY_WORDS);
    localparam logic [IW-1:0] LAST = IW'(KEY_WORDS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, EXHAUST} state_t;

    state_t            state, state_nx;
    logic [IW-1:0]     idx, idx_nx;
    logic [DATA_W-1:0] key [KEY_WORDS];
    logic              key_fire, pt_fire;

    // abort gates both ready signals so it always beats a same-cycle transfer
    assign key_ready  = state == LOAD && !abort;
    assign pt_ready   = state == RUN && !abort && (!ct_valid || ct_ready);
    assign key_fire   = key_valid && key_ready;
    assign pt_fire    = pt_valid && pt_ready;
    assign busy       = state == LOAD || state == RUN;
    assign exhausted  = state == EXHAUST;
    assign words_left = state == RUN ? CW'(KEY_WORDS) - CW'(idx) : '0;

    // state and key-word index register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // next state: load the pad, spend it word by word, then refuse input until restarted
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LOAD;
                    idx_nx   = '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                end else if (key_fire) begin
                    state_nx = idx == LAST ? RUN : LOAD;
                    idx_nx   = idx == LAST ? '0 : idx + IW'(1);
                end
            end
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                end else if (pt_fire) begin
                    state_nx = idx == LAST ? EXHAUST : RUN;
                    idx_nx   = idx == LAST ? '0 : idx + IW'(1);
                end
            end
            default: begin
                if (start && !ct_valid) begin
                    state_nx = LOAD;
                    idx_nx   = '0;
                end
            end
        endcase
    end

    // key bank: written during load, each word wiped as soon as it is used, all wiped on abort
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < KEY_WORDS; i++) key[i] <= '0;
        end else if (abort && busy) begin
            for (int i = 0; i < KEY_WORDS; i++) key[i] <= '0;
        end else if (key_fire) begin
            key[idx] <= key_data;
        end else if (pt_fire) begin
            key[idx] <= '0;
        end
    end

    // ciphertext register: holds under backpressure, refills on the same edge it drains
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ct_valid <= 1'b0;
            ct_data  <= '0;
        end else if (pt_fire) begin
            ct_valid <= 1'b1;
            ct_data  <= pt_data ^ key[idx];
        end else if (ct_ready) begin
            ct_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_otp_key_sequencer.sv
// tb_otp_key_sequencer: scoreboard bench for the one-time-pad sequencer
module tb_otp_key_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key_data = '0;
    logic       key_ready;
    logic       pt_valid = 1'b0;
    logic [7:0] pt_data = '0;
    logic       pt_ready;
    logic       ct_valid;
    logic [7:0] ct_data;
    logic       ct_ready = 1'b1;
    logic       busy;
    logic       exhausted;
    logic [2:0] words_left;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] sb [$];
    logic [7:0] exp_ct;

    otp_key_sequencer #(.DATA_W(8), .KEY_WORDS(4)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .key_valid(key_valid), .key_data(key_data), .key_ready(key_ready),
        .pt_valid(pt_valid), .pt_data(pt_data), .pt_ready(pt_ready),
        .ct_valid(ct_valid), .ct_data(ct_data), .ct_ready(ct_ready),
        .busy(busy), .exhausted(exhausted), .words_left(words_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ciphertext leaving the DUT is matched against the oldest expected word
    always @(negedge clk) begin
        if (reset && ct_valid && ct_ready) begin
            if (sb.size() == 0) begin
                chk("ct_unexpected", {24'd0, ct_data}, 32'hffff_ffff);
            end else begin
                exp_ct = sb.pop_front();
                chk("ct_data", {24'd0, ct_data}, {24'd0, exp_ct});
            end
        end
    end

    task automatic load_key(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2, input logic [7:0] k3);
        logic [7:0] k [4];
        k = '{k0, k1, k2, k3};
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            key_valid = 1'b1;
            key_data  = k[i];
            @(negedge clk);
            while (!key_ready && n < 20) begin
                n++;
                @(negedge clk);
            end
            if (!key_ready) chk("key_timeout", 0, 1);
            tick();
        end
        key_valid = 1'b0;
    endtask

    task automatic send_pt(input logic [7:0] d, input logic [7:0] e, input logic [2:0] wl);
        int n = 0;
        pt_valid = 1'b1;
        pt_data  = d;
        @(negedge clk);
        while (!pt_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!pt_ready) begin
            chk("pt_timeout", 0, 1);
        end else begin
            chk("words_left", {29'd0, words_left}, {29'd0, wl});
            sb.push_back(e);
        end
        tick();
        pt_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ct_valid", {31'd0, ct_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_key_ready", {31'd0, key_ready}, 0);
        reset = 1'b1;
        tick();

        // full-throughput pass
        pulse_start();
        load_key(8'hA5, 8'h3C, 8'hFF, 8'h00);
        send_pt(8'h11, 8'hB4, 3'd4);
        send_pt(8'h22, 8'h1E, 3'd3);
        send_pt(8'h33, 8'hCC, 3'd2);
        send_pt(8'h44, 8'h44, 3'd1);
        @(negedge clk);
        chk("t2_exhausted", {31'd0, exhausted}, 1);
        chk("t2_words_left", {29'd0, words_left}, 0);
        tick();

        // backpressure after the first ciphertext word
        pulse_start();
        load_key(8'hA5, 8'h3C, 8'hFF, 8'h00);
        send_pt(8'h11, 8'hB4, 3'd4);
        ct_ready = 1'b0;
        pt_valid = 1'b1;
        pt_data  = 8'h22;
        repeat (3) begin
            @(negedge clk);
            chk("t3_hold_data", {24'd0, ct_data}, 32'hB4);
            chk("t3_pt_ready", {31'd0, pt_ready}, 0);
        end
        tick();
        ct_ready = 1'b1;
        send_pt(8'h22, 8'h1E, 3'd3);
        send_pt(8'h33, 8'hCC, 3'd2);
        send_pt(8'h44, 8'h44, 3'd1);
        ct_ready = 1'b0;

        // exhausted: refuse plaintext, ignore start until ciphertext drains
        pt_valid = 1'b1;
        pt_data  = 8'h99;
        start    = 1'b1;
        @(negedge clk);
        chk("t4_exhausted", {31'd0, exhausted}, 1);
        chk("t4_ct_data", {24'd0, ct_data}, 32'h44);
        chk("t4_pt_ready", {31'd0, pt_ready}, 0);
        chk("t4_key_ready", {31'd0, key_ready}, 0);
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("t4_start_ignored", {31'd0, exhausted}, 1);
        tick();
        pt_valid = 1'b0;
        ct_ready = 1'b1;
        tick();
        pulse_start();
        @(negedge clk);
        chk("t4_load_key_ready", {31'd0, key_ready}, 1);
        chk("t4_load_busy", {31'd0, busy}, 1);
        tick();

        // abort beats a same-cycle plaintext transfer
        load_key(8'hA5, 8'h3C, 8'hFF, 8'h00);
        send_pt(8'h11, 8'hB4, 3'd4);
        send_pt(8'h22, 8'h1E, 3'd3);
        pt_valid = 1'b1;
        pt_data  = 8'h33;
        abort    = 1'b1;
        @(negedge clk);
        chk("t5_pt_ready", {31'd0, pt_ready}, 0);
        tick();
        abort    = 1'b0;
        pt_valid = 1'b0;
        @(negedge clk);
        chk("t5_busy", {31'd0, busy}, 0);
        chk("t5_words_left", {29'd0, words_left}, 0);
        tick();
        pulse_start();
        load_key(8'h01, 8'h02, 8'h03, 8'h04);
        send_pt(8'h00, 8'h01, 3'd4);

        // start and key words during RUN are ignored
        start     = 1'b1;
        key_valid = 1'b1;
        key_data  = 8'h55;
        @(negedge clk);
        chk("t6_key_ready", {31'd0, key_ready}, 0);
        tick();
        start     = 1'b0;
        key_valid = 1'b0;
        @(negedge clk);
        chk("t6_busy", {31'd0, busy}, 1);
        chk("t6_words_left", {29'd0, words_left}, 3);
        tick();
        send_pt(8'h00, 8'h02, 3'd3);
        send_pt(8'h00, 8'h03, 3'd2);
        send_pt(8'h00, 8'h04, 3'd1);
        @(negedge clk);
        chk("t6_exhausted", {31'd0, exhausted}, 1);
        tick();
        tick();

        // asynchronous reset mid-RUN with ciphertext pending
        pulse_start();
        load_key(8'hA5, 8'h3C, 8'hFF, 8'h00);
        ct_ready = 1'b0;
        send_pt(8'h11, 8'hB4, 3'd4);
        @(negedge clk);
        chk("t1_ct_pending", {31'd0, ct_valid}, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t1_ct_valid", {31'd0, ct_valid}, 0);
        chk("t1_ct_data", {24'd0, ct_data}, 0);
        chk("t1_busy", {31'd0, busy}, 0);
        chk("t1_words_left", {29'd0, words_left}, 0);
        chk("t1_pt_ready", {31'd0, pt_ready}, 0);
        sb.delete();
        tick();
        reset    = 1'b1;
        ct_ready = 1'b1;
        pt_valid = 1'b1;
        @(negedge clk);
        chk("t1_post_busy", {31'd0, busy}, 0);
        chk("t1_post_pt_ready", {31'd0, pt_ready}, 0);
        tick();
        pt_valid = 1'b0;
        tick();

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
